seq_checker: RTL
================

SEQ_CHECKER -- requirements
Module: seq_checker

Interface
REQ-001 The block SHALL have parameter NCH, default 4, number of independent channels, range 1..16.
REQ-002 The block SHALL have parameter MIN_DLY, default 1, earliest cycle after trigger at which cond is accepted, range 1..MAX_DLY.
REQ-003 The block SHALL have parameter MAX_DLY, default 3, latest cycle after trigger at which cond is accepted, range MIN_DLY..255.
REQ-004 The block SHALL have parameter CNT_W, default 8, width of the pass/fail counters, range 4..32.
REQ-005 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear.
- en  in  NCH  per-channel enable.
- trig  in  NCH  per-channel antecedent.
- cond  in  NCH  per-channel windowed condition.
- cons  in  NCH  per-channel consequent.
- busy  out  NCH  channel attempt in progress.
- pass_o  out  NCH  one-cycle pass pulse.
- fail_o  out  NCH  one-cycle fail pulse.
- overlap_o  out  NCH  sticky flag: trigger ignored while busy.
- pass_cnt  out  CNT_W  saturating pass total.
- fail_cnt  out  CNT_W  saturating fail total.
- first_fail_ch  out  4  lowest-index channel of the first failure.
- first_fail_vld  out  1  first_fail_ch holds a valid index.

Function
REQ-006 Each channel SHALL implement trig ##[MIN_DLY:MAX_DLY] cond |=> cons, sampled on rising clk, as a per-channel FSM with states IDLE, WAIT, CHECK.
REQ-007 In IDLE, an edge with en[i]=1 and trig[i]=1 SHALL move the channel to WAIT with k=0; this edge is the trigger edge T.
REQ-008 In WAIT, at edge T+k (k counts 1..MAX_DLY), cond[i]=1 with MIN_DLY<=k<=MAX_DLY SHALL move the channel to CHECK; cond[i] for k<MIN_DLY SHALL be ignored.
REQ-009 In WAIT, cond[i]=0 at k=MAX_DLY SHALL be a failure, and the channel SHALL return to IDLE.
REQ-010 In CHECK, at the next edge cons[i]=1 SHALL be a pass and cons[i]=0 a failure; either way the channel SHALL return to IDLE.
REQ-011 pass_o[i]/fail_o[i] SHALL be registered and SHALL go high at the deciding edge for exactly one cycle.
REQ-012 busy[i] SHALL be 1 in WAIT and CHECK and 0 in IDLE.
REQ-013 trig[i]=1 in WAIT or CHECK SHALL be ignored and SHALL set overlap_o[i], which stays set until clr or reset.
REQ-014 A trigger SHALL NOT be accepted at the edge on which a channel leaves CHECK or WAIT; acceptance resumes one edge later.
REQ-015 en[i]=0 in WAIT or CHECK SHALL abort the attempt to IDLE without pass or fail.
REQ-016 pass_cnt SHALL add the popcount of pass events at each edge and SHALL saturate at 2^CNT_W-1; fail_cnt SHALL do the same for fail events.
REQ-017 On the first failure since reset or clr, first_fail_vld SHALL set and first_fail_ch SHALL capture the lowest failing index; both SHALL then hold until clr or reset.
REQ-018 clr=1 SHALL return all FSMs to IDLE and zero the counters, overlap_o, first_fail_*, pass_o and fail_o at that edge.
REQ-019 clr SHALL take priority over any pass, fail or trigger at the same edge.

Reset
REQ-020 rst_n=0 SHALL immediately, without a clock, force all FSMs to IDLE and all outputs to 0.
REQ-021 No pass or fail pulse SHALL be produced for an attempt in progress at reset, including after rst_n deasserts.
REQ-022 Deassertion of rst_n SHALL be synchronised internally to clk before FSMs respond.

Verification (NCH=4, MIN_DLY=1, MAX_DLY=3, CNT_W=8 unless stated)
REQ-023 ch0: trig at edge T, cond at T+2, cons at T+3 -> pass_o[0] high for one cycle after T+3, pass_cnt=1, busy[0]=0 after T+3.
REQ-024 ch0: trig at T, cond low through T+3 -> fail_o[0] at T+3, fail_cnt=1, first_fail_ch=0, first_fail_vld=1.
REQ-025 ch1 and ch3 fail at the same edge -> fail_cnt increments by 2, first_fail_ch=1.
REQ-026 CNT_W=4: 17 passes -> pass_cnt=15, holds at 15; clr coincident with a fail -> fail_cnt=0, fail_o=0.
REQ-027 ch2: trig at T, trig again at T+1 -> second trigger ignored, overlap_o[2]=1, single outcome at the window end.
REQ-028 rst_n pulsed low during WAIT -> outputs 0 immediately, no pulse after release; en[0] dropped in WAIT -> busy[0]=0 next edge, no pass or fail.

Source files
------------

// File: rtl/seq_checker.sv
// Multi-channel windowed sequence checker: trig ##[MIN_DLY:MAX_DLY] cond |=> cons,
// with registered pass/fail pulses, saturating totals and first-failure capture.
module seq_checker #(
    parameter int NCH     = 4,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [NCH-1:0]   en,
    input  logic [NCH-1:0]   trig,
    input  logic [NCH-1:0]   cond,
    input  logic [NCH-1:0]   cons,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   pass_o,
    output logic [NCH-1:0]   fail_o,
    output logic [NCH-1:0]   overlap_o,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [3:0]       first_fail_ch,
    output logic             first_fail_vld
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_CHECK = 2'd2} state_t;

    localparam int SUM_W = CNT_W + 6;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    state_t           r_state [NCH];
    state_t           w_state_nxt [NCH];
    logic [7:0]       r_k [NCH];
    logic [7:0]       w_k_nxt [NCH];
    logic [NCH-1:0]   r_pass, r_fail, r_ovl;
    logic [NCH-1:0]   w_pass_ev, w_fail_ev, w_ovl_nxt;
    logic [CNT_W-1:0] r_pass_cnt, r_fail_cnt, w_pass_cnt_nxt, w_fail_cnt_nxt;
    logic [SUM_W-1:0] w_pass_sum, w_fail_sum;
    logic [3:0]       r_ff_ch, w_ff_ch_nxt;
    logic             r_ff_vld, w_ff_vld_nxt;
    logic [1:0]       r_rst_sync;
    logic             w_srst;

    function automatic logic [5:0] f_popcount(input logic [NCH-1:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < NCH; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [3:0] f_lowest(input logic [NCH-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Release of rst_n is only seen by the FSMs once it has crossed two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_srst = clr | ~r_rst_sync[1];

    // State register: channel FSMs, pulses, sticky flags and totals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= S_IDLE;
                r_k[i]     <= 8'd0;
            end
            r_pass     <= {NCH{1'b0}};
            r_fail     <= {NCH{1'b0}};
            r_ovl      <= {NCH{1'b0}};
            r_pass_cnt <= {CNT_W{1'b0}};
            r_fail_cnt <= {CNT_W{1'b0}};
            r_ff_ch    <= 4'd0;
            r_ff_vld   <= 1'b0;
        end else if (w_srst) begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= S_IDLE;
                r_k[i]     <= 8'd0;
            end
            r_pass     <= {NCH{1'b0}};
            r_fail     <= {NCH{1'b0}};
            r_ovl      <= {NCH{1'b0}};
            r_pass_cnt <= {CNT_W{1'b0}};
            r_fail_cnt <= {CNT_W{1'b0}};
            r_ff_ch    <= 4'd0;
            r_ff_vld   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_k[i]     <= w_k_nxt[i];
            end
            r_pass     <= w_pass_ev;
            r_fail     <= w_fail_ev;
            r_ovl      <= w_ovl_nxt;
            r_pass_cnt <= w_pass_cnt_nxt;
            r_fail_cnt <= w_fail_cnt_nxt;
            r_ff_ch    <= w_ff_ch_nxt;
            r_ff_vld   <= w_ff_vld_nxt;
        end
    end

    // Next-state logic; r_k holds the offset of the previous edge from the trigger edge.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_k_nxt[i]     = r_k[i];
            w_pass_ev[i]   = 1'b0;
            w_fail_ev[i]   = 1'b0;
            w_ovl_nxt[i]   = r_ovl[i] | (trig[i] & (r_state[i] != S_IDLE));
            case (r_state[i])
                S_IDLE: begin
                    if (en[i] && trig[i]) begin
                        w_state_nxt[i] = S_WAIT;
                        w_k_nxt[i]     = 8'd0;
                    end else begin
                        w_state_nxt[i] = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!en[i]) begin
                        w_state_nxt[i] = S_IDLE;
                    end else if (cond[i] && ((r_k[i] + 8'd1) >= 8'(MIN_DLY))) begin
                        w_state_nxt[i] = S_CHECK;
                    end else if ((r_k[i] + 8'd1) == 8'(MAX_DLY)) begin
                        w_state_nxt[i] = S_IDLE;
                        w_fail_ev[i]   = 1'b1;
                    end else begin
                        w_k_nxt[i] = r_k[i] + 8'd1;
                    end
                end
                S_CHECK: begin
                    w_state_nxt[i] = S_IDLE;
                    if (!en[i]) begin
                        w_pass_ev[i] = 1'b0;
                    end else if (cons[i]) begin
                        w_pass_ev[i] = 1'b1;
                    end else begin
                        w_fail_ev[i] = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                end
            endcase
        end
    end

    // Saturating totals and first-failure capture.
    always_comb begin
        w_pass_sum = SUM_W'(r_pass_cnt) + SUM_W'(f_popcount(w_pass_ev));
        w_fail_sum = SUM_W'(r_fail_cnt) + SUM_W'(f_popcount(w_fail_ev));
        if (w_pass_sum > CNT_MAX) begin
            w_pass_cnt_nxt = {CNT_W{1'b1}};
        end else begin
            w_pass_cnt_nxt = w_pass_sum[CNT_W-1:0];
        end
        if (w_fail_sum > CNT_MAX) begin
            w_fail_cnt_nxt = {CNT_W{1'b1}};
        end else begin
            w_fail_cnt_nxt = w_fail_sum[CNT_W-1:0];
        end
        if (!r_ff_vld && (|w_fail_ev)) begin
            w_ff_vld_nxt = 1'b1;
            w_ff_ch_nxt  = f_lowest(w_fail_ev);
        end else begin
            w_ff_vld_nxt = r_ff_vld;
            w_ff_ch_nxt  = r_ff_ch;
        end
    end

    // Output decode.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (r_state[i] != S_IDLE);
        end
        pass_o         = r_pass;
        fail_o         = r_fail;
        overlap_o      = r_ovl;
        pass_cnt       = r_pass_cnt;
        fail_cnt       = r_fail_cnt;
        first_fail_ch  = r_ff_ch;
        first_fail_vld = r_ff_vld;
    end

endmodule
